// File: rtl/seg_scan_scheduler.sv
// Multiplexed 7-segment refresh scheduler for a 16-bit 74HC595 chain.
// Holds a digit buffer, builds one {segments, select} frame per digit,
// offers it over valid/ready and dwells before moving to the next digit.
module seg_scan_scheduler #(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned DWELL_CYCLES = 1000
) (
  input  logic        s_clk,
  input  logic        s_reset,
  input  logic        digit_we,
  input  logic [2:0]  digit_addr,
  input  logic [4:0]  digit_code,
  input  logic        digit_dp,
  input  logic        display_en,
  output logic [15:0] frame_data,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [2:0]  scan_idx,
  output logic        busy
);

  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned CNT_W      = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [2:0]       LAST_IDX = 3'(DIGITS - 1);
  localparam logic [4:0]       BLANK_CODE = 5'h10;
  localparam logic [15:0]      ALL_OFF    = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SEND  = 3'd2,
    DWELL = 3'd3,
    BLANK = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] dwell_cnt;
  logic [4:0]       code_q [MAX_DIGITS];
  logic             dp_q   [MAX_DIGITS];

  logic             addr_ok_c;
  logic [7:0]       seg_c;
  logic [7:0]       sel_c;
  logic [2:0]       next_idx_c;

  // Active-low a..g pattern for a hex value (bit 0 = a).
  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Frame contents for the digit currently addressed by scan_idx.
  always_comb begin
    addr_ok_c  = ({1'b0, digit_addr} < 4'(DIGITS));
    seg_c      = code_q[scan_idx][4] ? 8'hFF
                                     : {~dp_q[scan_idx], glyph(code_q[scan_idx][3:0])};
    sel_c      = ~(8'h01 << scan_idx);
    next_idx_c = (scan_idx == LAST_IDX) ? 3'd0 : scan_idx + 3'd1;
  end

  // Digit buffer: reset to blank, writes to out-of-range entries dropped.
  always_ff @(posedge s_clk) begin
    if (s_reset) begin
      for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
        code_q[i] <= BLANK_CODE;
        dp_q[i]   <= 1'b0;
      end
    end else if (digit_we && addr_ok_c) begin
      code_q[digit_addr] <= digit_code;
      dp_q[digit_addr]   <= digit_dp;
    end
  end

  // Scan FSM with registered frame, handshake and status outputs.
  always_ff @(posedge s_clk) begin
    if (s_reset) begin
      state       <= IDLE;
      frame_data  <= ALL_OFF;
      frame_valid <= 1'b0;
      scan_idx    <= 3'd0;
      busy        <= 1'b0;
      dwell_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          frame_valid <= 1'b0;
          if (display_en) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          frame_data  <= {seg_c, sel_c};
          frame_valid <= 1'b1;
          state       <= SEND;
        end
        SEND: begin
          if (frame_ready) begin
            frame_valid <= 1'b0;
            dwell_cnt   <= '0;
            state       <= DWELL;
          end
        end
        DWELL: begin
          if (dwell_cnt == LAST_CNT) begin
            dwell_cnt <= '0;
            scan_idx  <= next_idx_c;
            if (display_en) begin
              state <= LOAD;
            end else begin
              frame_data  <= ALL_OFF;
              frame_valid <= 1'b1;
              state       <= BLANK;
            end
          end else begin
            dwell_cnt <= dwell_cnt + CNT_W'(1);
          end
        end
        BLANK: begin
          if (frame_ready) begin
            frame_valid <= 1'b0;
            scan_idx    <= 3'd0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          frame_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed bench for seg_scan_scheduler: decode table sweeps plus
// handshake stall, dwell length, shutdown, late write and reset cases.
module tb_seg_scan_scheduler;

  logic        clk = 1'b0;
  logic        s_reset;
  logic        digit_we;
  logic [2:0]  digit_addr;
  logic [4:0]  digit_code;
  logic        digit_dp;
  logic        display_en;
  logic        frame_ready;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic [2:0]  scan_idx;
  logic        busy;

  logic        display_en6;
  logic        frame_ready6;
  logic [15:0] frame_data6;
  logic        frame_valid6;
  logic [2:0]  scan_idx6;
  logic        busy6;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  code;
    logic        dp;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [24];

  seg_scan_scheduler #(.DIGITS(8), .DWELL_CYCLES(4)) dut (
    .s_clk(clk), .s_reset(s_reset), .digit_we(digit_we), .digit_addr(digit_addr),
    .digit_code(digit_code), .digit_dp(digit_dp), .display_en(display_en),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .scan_idx(scan_idx), .busy(busy)
  );

  seg_scan_scheduler #(.DIGITS(6), .DWELL_CYCLES(4)) dut6 (
    .s_clk(clk), .s_reset(s_reset), .digit_we(digit_we), .digit_addr(digit_addr),
    .digit_code(digit_code), .digit_dp(digit_dp), .display_en(display_en6),
    .frame_data(frame_data6), .frame_valid(frame_valid6), .frame_ready(frame_ready6),
    .scan_idx(scan_idx6), .busy(busy6)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    display_en   = 1'b0;
    display_en6  = 1'b0;
    s_reset      = 1'b1;
    tick();
    tick();
    s_reset      = 1'b0;
  endtask

  task automatic write_digit(input logic [2:0] a, input logic [4:0] c, input logic p);
    digit_we   = 1'b1;
    digit_addr = a;
    digit_code = c;
    digit_dp   = p;
    tick();
    digit_we   = 1'b0;
  endtask

  // Waits for a transfer on the chosen instance, returns the frame and
  // leaves the bench at the sample point just after the transfer edge.
  task automatic get_frame(input bit use6, output logic [15:0] d);
    bit got;
    got = 1'b0;
    d   = 16'hDEAD;
    for (int k = 0; k < 100; k++) begin
      if (use6 ? (frame_valid6 && frame_ready6) : (frame_valid && frame_ready)) begin
        d   = use6 ? frame_data6 : frame_data;
        got = 1'b1;
        tick();
        break;
      end
      tick();
    end
    if (!got) check("frame_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [15:0] d;
    logic [15:0] seq [8];
    logic [15:0] seq6 [6];

    vecs[0]  = '{5'h00, 1'b0, 16'hC0FE};
    vecs[1]  = '{5'h01, 1'b1, 16'h79FD};
    vecs[2]  = '{5'h02, 1'b0, 16'hA4FB};
    vecs[3]  = '{5'h03, 1'b0, 16'hB0F7};
    vecs[4]  = '{5'h04, 1'b1, 16'h19EF};
    vecs[5]  = '{5'h05, 1'b0, 16'h92DF};
    vecs[6]  = '{5'h06, 1'b0, 16'h82BF};
    vecs[7]  = '{5'h07, 1'b0, 16'hF87F};
    vecs[8]  = '{5'h08, 1'b0, 16'h80FE};
    vecs[9]  = '{5'h09, 1'b0, 16'h90FD};
    vecs[10] = '{5'h0A, 1'b1, 16'h08FB};
    vecs[11] = '{5'h0B, 1'b0, 16'h83F7};
    vecs[12] = '{5'h0C, 1'b0, 16'hC6EF};
    vecs[13] = '{5'h0D, 1'b0, 16'hA1DF};
    vecs[14] = '{5'h0E, 1'b1, 16'h06BF};
    vecs[15] = '{5'h0F, 1'b0, 16'h8E7F};
    vecs[16] = '{5'h10, 1'b1, 16'hFFFE};
    vecs[17] = '{5'h0E, 1'b0, 16'h86FD};
    vecs[18] = '{5'h1F, 1'b0, 16'hFFFB};
    vecs[19] = '{5'h0F, 1'b1, 16'h0EF7};
    vecs[20] = '{5'h00, 1'b1, 16'h40EF};
    vecs[21] = '{5'h13, 1'b1, 16'hFFDF};
    vecs[22] = '{5'h09, 1'b1, 16'h10BF};
    vecs[23] = '{5'h02, 1'b1, 16'h247F};

    digit_we     = 1'b0;
    digit_addr   = 3'd0;
    digit_code   = 5'd0;
    digit_dp     = 1'b0;
    frame_ready  = 1'b0;
    frame_ready6 = 1'b1;

    // Reset state and first-frame latency from a blank buffer.
    do_reset();
    check("rst_frame", 32'(frame_data), 32'hFFFF);
    check("rst_valid", 32'(frame_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_idx", 32'(scan_idx), 32'd0);
    display_en  = 1'b1;
    frame_ready = 1'b1;
    tick();
    check("lat_load_busy", 32'(busy), 32'd1);
    check("lat_load_valid", 32'(frame_valid), 32'd0);
    tick();
    check("lat_send_valid", 32'(frame_valid), 32'd1);
    check("lat_first_frame", 32'(frame_data), 32'hFFFE);
    display_en = 1'b0;
    tick();
    check("lat_xfer_valid", 32'(frame_valid), 32'd0);
    get_frame(1'b0, d);
    check("lat_blank_frame", 32'(d), 32'hFFFF);
    check("lat_idle_busy", 32'(busy), 32'd0);

    // Decode table: three sweeps of eight digits, then wrap and shut down.
    for (int p = 0; p < 3; p++) begin
      do_reset();
      for (int i = 0; i < 8; i++)
        write_digit(3'(i), vecs[p*8+i].code, vecs[p*8+i].dp);
      display_en  = 1'b1;
      frame_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
        get_frame(1'b0, d);
        check("tbl_frame", 32'(d), 32'(vecs[p*8+i].exp));
        check("tbl_idx", 32'(scan_idx), 32'(i));
      end
      get_frame(1'b0, d);
      check("tbl_wrap_frame", 32'(d), 32'(vecs[p*8].exp));
      display_en = 1'b0;
      get_frame(1'b0, d);
      check("tbl_blank_frame", 32'(d), 32'hFFFF);
      check("tbl_blank_idx", 32'(scan_idx), 32'd0);
      check("tbl_blank_busy", 32'(busy), 32'd0);
    end

    // Stall in SEND, single transfer, exact dwell length.
    do_reset();
    write_digit(3'd0, 5'h03, 1'b1);
    write_digit(3'd1, 5'h0A, 1'b0);
    frame_ready = 1'b0;
    display_en  = 1'b1;
    for (int k = 0; k < 10 && !frame_valid; k++) tick();
    check("stall_valid", 32'(frame_valid), 32'd1);
    check("stall_frame", 32'(frame_data), 32'h30FE);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("stall_hold_valid", 32'(frame_valid), 32'd1);
      check("stall_hold_frame", 32'(frame_data), 32'h30FE);
    end
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    check("xfer_valid_drop", 32'(frame_valid), 32'd0);
    check("xfer_busy", 32'(busy), 32'd1);
    check("xfer_idx", 32'(scan_idx), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("dwell_quiet", 32'(frame_valid), 32'd0);
    end
    tick();
    check("dwell_next_valid", 32'(frame_valid), 32'd1);
    check("dwell_next_frame", 32'(frame_data), 32'h88FD);
    check("dwell_next_idx", 32'(scan_idx), 32'd1);

    // Late write to digit 2 while it dwells, then shutdown from its dwell.
    frame_ready = 1'b1;
    get_frame(1'b0, d);
    get_frame(1'b0, d);
    check("d2_first_frame", 32'(d), 32'hFFFB);
    write_digit(3'd2, 5'h07, 1'b0);
    check("d2_frame_kept", 32'(frame_data), 32'hFFFB);
    check("d2_idx_kept", 32'(scan_idx), 32'd2);
    seq[0] = 16'hFFF7; seq[1] = 16'hFFEF; seq[2] = 16'hFFDF; seq[3] = 16'hFFBF;
    seq[4] = 16'hFF7F; seq[5] = 16'h30FE; seq[6] = 16'h88FD; seq[7] = 16'hF8FB;
    for (int i = 0; i < 8; i++) begin
      get_frame(1'b0, d);
      check("revisit_frame", 32'(d), 32'(seq[i]));
    end
    display_en = 1'b0;
    get_frame(1'b0, d);
    check("off_blank_frame", 32'(d), 32'hFFFF);
    check("off_busy", 32'(busy), 32'd0);
    check("off_idx", 32'(scan_idx), 32'd0);
    check("off_valid", 32'(frame_valid), 32'd0);

    // Reset asserted while a frame is pending.
    frame_ready = 1'b0;
    display_en  = 1'b1;
    for (int k = 0; k < 10 && !frame_valid; k++) tick();
    check("rs_pre_frame", 32'(frame_data), 32'h30FE);
    s_reset = 1'b1;
    tick();
    check("rs_valid", 32'(frame_valid), 32'd0);
    check("rs_frame", 32'(frame_data), 32'hFFFF);
    check("rs_busy", 32'(busy), 32'd0);
    s_reset     = 1'b0;
    frame_ready = 1'b1;
    get_frame(1'b0, d);
    check("rs_restart_d0", 32'(d), 32'hFFFE);
    get_frame(1'b0, d);
    check("rs_restart_d1", 32'(d), 32'hFFFD);
    display_en = 1'b0;
    get_frame(1'b0, d);
    check("rs_drain", 32'(d), 32'hFFFF);

    // Six-digit instance: out-of-range writes dropped, wrap after digit 5.
    do_reset();
    write_digit(3'd7, 5'h01, 1'b1);
    write_digit(3'd6, 5'h03, 1'b0);
    write_digit(3'd5, 5'h02, 1'b0);
    display_en6 = 1'b1;
    seq6[0] = 16'hFFFE; seq6[1] = 16'hFFFD; seq6[2] = 16'hFFFB;
    seq6[3] = 16'hFFF7; seq6[4] = 16'hFFEF; seq6[5] = 16'hA4DF;
    for (int i = 0; i < 6; i++) begin
      get_frame(1'b1, d);
      check("d6_frame", 32'(d), 32'(seq6[i]));
    end
    get_frame(1'b1, d);
    check("d6_wrap_frame", 32'(d), 32'hFFFE);
    check("d6_wrap_idx", 32'(scan_idx6), 32'd0);
    display_en6 = 1'b0;
    get_frame(1'b1, d);
    check("d6_blank", 32'(d), 32'hFFFF);
    check("d6_busy", 32'(busy6), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
